mul_div_unit: RTL

Iterative 32-bit multiply/divide unit for the processor's execute stage. It takes the two source operands read from the register table, computes one of four results over a fixed number of cycles, and hands the result and destination index to the register table write port. While it works, it holds `busy` high so the pipeline stalls until the write-back pulse.

---
 rtl/mul_div_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MUL/MULHU and restoring
// DIVU/REMU, one iteration per clock, fixed XLEN-cycle latency.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      dest_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest_out,
  output logic            write_register_d
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_r;
  logic [4:0]         dest_r;
  // opa: multiplicand (MUL) or dividend shifting into quotient (DIV)
  // opb: multiplier shifting right (MUL) or divisor (DIV)
  logic [XLEN-1:0]    opa;
  logic [XLEN-1:0]    opb;
  logic [2*XLEN-1:0]  acc;
  logic [XLEN-1:0]    rem;

  logic [XLEN:0]      sum;
  logic [2*XLEN-1:0]  acc_nxt;
  logic [XLEN:0]      shifted;
  logic [XLEN:0]      diff;
  logic [XLEN-1:0]    rem_nxt;
  logic [XLEN-1:0]    quo_nxt;
  logic [XLEN-1:0]    res_nxt;

  always_comb begin
    // Multiply: add multiplicand into the upper half, then shift the whole
    // product right so the next multiplier bit lines up with the upper half.
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (opb[0] ? opa : '0)};
    acc_nxt = {sum, acc[XLEN-1:1]};

    // Restoring divide: the borrow of the XLEN+1 bit subtract is diff[XLEN].
    shifted = {rem, opa[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt = {opa[XLEN-2:0], ~diff[XLEN]};

    res_nxt = '0;
    case (op_r)
      2'b00:   res_nxt = acc_nxt[XLEN-1:0];
      2'b01:   res_nxt = acc_nxt[2*XLEN-1:XLEN];
      2'b10:   res_nxt = quo_nxt;
      default: res_nxt = rem_nxt;
    endcase
  end

  // Control state: FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      dest_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result   <= res_nxt;
            dest_out <= dest_r;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath registers: no reset, qualified by the control state only.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r   <= op;
      dest_r <= dest_in;
      opa    <= operand_a;
      opb    <= operand_b;
      acc    <= '0;
      rem    <= '0;
    end else if (state == BUSY) begin
      if (op_r[1]) begin
        opa <= quo_nxt;
        rem <= rem_nxt;
      end else begin
        acc <= acc_nxt;
        opb <= opb >> 1;
      end
    end
  end

  assign write_register_d = done;

endmodule
